// File: rtl/sdhci_dat_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | sdhci_dat_pkg : state, bus-width codes and timeout base for dat_seq        |
// | rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
package sdhci_dat_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WAIT_CMD   = 4'd1,
        ST_WAIT_BUF   = 4'd2,
        ST_START      = 4'd3,
        ST_XFER       = 4'd4,
        ST_BLOCK_DONE = 4'd5,
        ST_GAP_STOP   = 4'd6,
        ST_BUSY_WAIT  = 4'd7,
        ST_DRAIN      = 4'd8,
        ST_ABORT      = 4'd9,
        ST_DONE       = 4'd10
    } dat_seq_state_e;

    localparam logic [1:0]  DatWidth1     = 2'd0;
    localparam logic [1:0]  DatWidth4     = 2'd1;
    localparam logic [1:0]  DatWidth8     = 2'd2;
    localparam int unsigned TimeoutBase   = 13;
    localparam int unsigned TimeoutSelMax = 14;

    // Physical lines used by a width code; 0 marks the reserved code.
    function automatic int unsigned dat_width_lines(input logic [1:0] w);
        case (w)
            DatWidth1: return 1;
            DatWidth4: return 4;
            DatWidth8: return 8;
            default:   return 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dat_seq_timeout.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | dat_seq_timeout : prescaled saturating data timeout, limit 2^(13+sel)      |
// | rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module dat_seq_timeout
    import sdhci_dat_pkg::*;
#(
    parameter int unsigned TimeoutDiv = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_i,
    input  logic       clear_i,
    input  logic [3:0] sel_i,
    output logic       elapsed_o
);

    localparam int unsigned CntW = TimeoutBase + TimeoutSelMax + 1;
    localparam int unsigned DivW = (TimeoutDiv > 1) ? $clog2(TimeoutDiv) : 1;

    logic [DivW-1:0] r_div;
    logic [CntW-1:0] r_cnt;
    logic            w_tick;
    logic [3:0]      w_sel;
    logic [CntW-1:0] w_limit;

    assign w_tick    = run_i && (r_div == DivW'(TimeoutDiv - 1));
    assign w_sel     = (sel_i > 4'(TimeoutSelMax)) ? 4'(TimeoutSelMax) : sel_i;
    assign w_limit   = CntW'(1) << (TimeoutBase + 32'(w_sel));
    assign elapsed_o = (r_cnt >= w_limit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (clear_i) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (run_i) begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dat_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | dat_seq : SD data-line block sequencer; SDHCI_DAT_BLOCK_GAP_EN adds gaps  |
// | rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module dat_seq
    import sdhci_dat_pkg::*;
#(
    parameter int unsigned NumDatLines     = 4,
    parameter int unsigned BlockCountWidth = 16,
    parameter int unsigned TimeoutDiv      = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       sd_clk_en_p_i,
    input  logic                       start_i,
    input  logic                       dir_read_i,
    input  logic [1:0]                 bus_width_i,
    input  logic [BlockCountWidth-1:0] block_count_i,
    input  logic                       auto_cmd12_en_i,
    input  logic [3:0]                 timeout_sel_i,
    input  logic                       cmd_done_i,
    input  logic                       rsp_done_i,
    input  logic                       stop_gap_i,
    input  logic                       continue_i,
    input  logic                       buf_space_i,
    input  logic                       buf_avail_i,
    input  logic                       buf_empty_i,
    input  logic                       dat0_i,
    output logic                       eng_start_o,
    output logic [1:0]                 eng_width_o,
    input  logic                       eng_waiting_i,
    input  logic                       eng_done_i,
    input  logic                       eng_crc_err_i,
    input  logic                       eng_end_err_i,
    output logic                       pause_sd_clk_o,
    output logic                       read_active_o,
    output logic                       write_active_o,
    output logic                       request_cmd12_o,
    output logic                       gap_event_o,
    output logic                       xfer_complete_o,
    output logic                       crc_err_o,
    output logic                       end_err_o,
    output logic                       timeout_err_o,
    output logic                       width_err_o,
    output logic [BlockCountWidth-1:0] blocks_left_o
);

    dat_seq_state_e             r_state, w_next;
    logic                       r_dir_read, r_auto12, r_tmo_cause;
    logic                       r_crc_flag, r_end_flag;
    logic [1:0]                 r_width;
    logic [3:0]                 r_tsel;
    logic [BlockCountWidth-1:0] r_count;
    logic                       r_cmd12, r_crc_err, r_end_err, r_tmo_err, r_width_err;
    logic                       w_width_bad, w_accept, w_last, w_err, w_tmo, w_run, w_clear;
    logic                       w_gap_req, w_continue;

`ifdef SDHCI_DAT_BLOCK_GAP_EN
    logic r_gap;
    assign w_gap_req   = stop_gap_i;
    assign w_continue  = continue_i;
    assign gap_event_o = r_gap;
`else
    logic w_unused_gap;
    assign w_unused_gap = stop_gap_i ^ continue_i;
    assign w_gap_req    = 1'b0;
    assign w_continue   = 1'b0;
    assign gap_event_o  = 1'b0;
`endif

    assign w_width_bad = (bus_width_i == 2'd3) || (dat_width_lines(bus_width_i) > NumDatLines);
    assign w_accept    = (r_state == ST_IDLE) && start_i && !w_width_bad;
    assign w_last      = (r_count <= BlockCountWidth'(1));
    assign w_err       = r_crc_flag || r_end_flag;
    assign w_run       = ((r_state == ST_XFER) && eng_waiting_i) || (r_state == ST_BUSY_WAIT);
    assign w_clear     = (w_next != r_state);

    dat_seq_timeout #(.TimeoutDiv(TimeoutDiv)) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .run_i     (w_run),
        .clear_i   (w_clear),
        .sel_i     (r_tsel),
        .elapsed_o (w_tmo)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_accept) w_next = ST_WAIT_CMD;
            ST_WAIT_CMD:   if (r_dir_read ? cmd_done_i : rsp_done_i) w_next = ST_WAIT_BUF;
            ST_WAIT_BUF:   if (r_dir_read ? buf_space_i : buf_avail_i) w_next = ST_START;
            ST_START:      if (sd_clk_en_p_i) w_next = ST_XFER;
            ST_XFER: begin
                if (w_tmo)           w_next = ST_ABORT;
                else if (eng_done_i) w_next = ST_BLOCK_DONE;
            end
            ST_BLOCK_DONE: begin
                if (w_err)          w_next = ST_ABORT;
                else if (w_last)    w_next = r_dir_read ? ST_DRAIN : ST_BUSY_WAIT;
                else if (w_gap_req) w_next = ST_GAP_STOP;
                else                w_next = ST_WAIT_BUF;
            end
            ST_GAP_STOP:   if (w_continue) w_next = ST_WAIT_BUF;
            ST_BUSY_WAIT: begin
                if (w_tmo)       w_next = ST_ABORT;
                else if (dat0_i) w_next = ST_DONE;
            end
            ST_DRAIN:      if (buf_empty_i) w_next = ST_DONE;
            ST_ABORT:      w_next = ST_DONE;
            ST_DONE:       w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dir_read  <= 1'b0;
            r_auto12    <= 1'b0;
            r_width     <= '0;
            r_tsel      <= '0;
            r_count     <= '0;
            r_crc_flag  <= 1'b0;
            r_end_flag  <= 1'b0;
            r_tmo_cause <= 1'b0;
            r_cmd12     <= 1'b0;
            r_crc_err   <= 1'b0;
            r_end_err   <= 1'b0;
            r_tmo_err   <= 1'b0;
            r_width_err <= 1'b0;
`ifdef SDHCI_DAT_BLOCK_GAP_EN
            r_gap       <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_dir_read  <= dir_read_i;
                r_auto12    <= auto_cmd12_en_i;
                r_width     <= bus_width_i;
                r_tsel      <= timeout_sel_i;
                r_count     <= (block_count_i == '0) ? BlockCountWidth'(1) : block_count_i;
                r_crc_flag  <= 1'b0;
                r_end_flag  <= 1'b0;
                r_tmo_cause <= 1'b0;
            end
            if ((r_state == ST_XFER) && (w_next == ST_BLOCK_DONE)) begin
                r_crc_flag <= eng_crc_err_i;
                r_end_flag <= eng_end_err_i;
            end
            if ((r_state == ST_BLOCK_DONE) && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
            // Only XFER and BUSY_WAIT reach ABORT through the timeout.
            if (w_clear && (w_next == ST_ABORT)) begin
                r_tmo_cause <= (r_state != ST_BLOCK_DONE);
            end
            r_width_err <= (r_state == ST_IDLE) && start_i && w_width_bad;
            r_crc_err   <= (r_state == ST_BLOCK_DONE) && r_crc_flag;
            r_end_err   <= (r_state == ST_BLOCK_DONE) && r_end_flag;
            r_tmo_err   <= (r_state == ST_ABORT) && r_tmo_cause;
            r_cmd12     <= r_auto12 && w_clear &&
                           (w_next inside {ST_BUSY_WAIT, ST_DRAIN, ST_ABORT});
`ifdef SDHCI_DAT_BLOCK_GAP_EN
            r_gap       <= w_clear && (w_next == ST_GAP_STOP);
`endif
        end
    end

    always_comb begin
        eng_start_o     = (r_state == ST_START);
        pause_sd_clk_o  = r_dir_read && ((r_state == ST_WAIT_BUF) || (r_state == ST_GAP_STOP));
        read_active_o   = r_dir_read && (r_state != ST_IDLE);
        write_active_o  = !r_dir_read && (r_state != ST_IDLE);
        xfer_complete_o = (r_state == ST_DONE);
    end

    assign eng_width_o     = r_width;
    assign blocks_left_o   = r_count;
    assign request_cmd12_o = r_cmd12;
    assign crc_err_o       = r_crc_err;
    assign end_err_o       = r_end_err;
    assign timeout_err_o   = r_tmo_err;
    assign width_err_o     = r_width_err;

endmodule
`default_nettype wire

// File: tb/tb_dat_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_dat_seq : reactive environment and transaction-level model for dat_seq |
// | rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module tb_dat_seq;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        sd_clk_en_p_i = 1'b0, start_i = 1'b0, dir_read_i = 1'b0;
    logic [1:0]  bus_width_i = '0;
    logic [15:0] block_count_i = '0;
    logic        auto_cmd12_en_i = 1'b0;
    logic [3:0]  timeout_sel_i = '0;
    logic        cmd_done_i = 1'b0, rsp_done_i = 1'b0, stop_gap_i = 1'b0, continue_i = 1'b0;
    logic        buf_space_i = 1'b0, buf_avail_i = 1'b0, buf_empty_i = 1'b1, dat0_i = 1'b1;
    logic        eng_waiting_i = 1'b0, eng_done_i = 1'b0, eng_crc_err_i = 1'b0, eng_end_err_i = 1'b0;
    logic        eng_start_o, pause_sd_clk_o, read_active_o, write_active_o;
    logic        request_cmd12_o, gap_event_o, xfer_complete_o;
    logic        crc_err_o, end_err_o, timeout_err_o, width_err_o;
    logic [1:0]  eng_width_o;
    logic [15:0] blocks_left_o;

    int total = 0, bad = 0;
    int n_start = 0, n_cmpl = 0, n_cmd12 = 0, n_crc = 0, n_end = 0, n_tmo = 0, n_werr = 0, n_gap = 0;
    logic prev_start = 1'b0;

    always #5 clk_i = ~clk_i;

    dat_seq #(.NumDatLines(4), .BlockCountWidth(16), .TimeoutDiv(1)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sd_clk_en_p_i(sd_clk_en_p_i), .start_i(start_i),
        .dir_read_i(dir_read_i), .bus_width_i(bus_width_i), .block_count_i(block_count_i),
        .auto_cmd12_en_i(auto_cmd12_en_i), .timeout_sel_i(timeout_sel_i),
        .cmd_done_i(cmd_done_i), .rsp_done_i(rsp_done_i), .stop_gap_i(stop_gap_i),
        .continue_i(continue_i), .buf_space_i(buf_space_i), .buf_avail_i(buf_avail_i),
        .buf_empty_i(buf_empty_i), .dat0_i(dat0_i), .eng_start_o(eng_start_o),
        .eng_width_o(eng_width_o), .eng_waiting_i(eng_waiting_i), .eng_done_i(eng_done_i),
        .eng_crc_err_i(eng_crc_err_i), .eng_end_err_i(eng_end_err_i),
        .pause_sd_clk_o(pause_sd_clk_o), .read_active_o(read_active_o),
        .write_active_o(write_active_o), .request_cmd12_o(request_cmd12_o),
        .gap_event_o(gap_event_o), .xfer_complete_o(xfer_complete_o), .crc_err_o(crc_err_o),
        .end_err_o(end_err_o), .timeout_err_o(timeout_err_o), .width_err_o(width_err_o),
        .blocks_left_o(blocks_left_o)
    );

    // Event counters: one-cycle pulses count per high cycle, eng_start per episode.
    always @(negedge clk_i) begin
        prev_start <= eng_start_o;
        if (eng_start_o && !prev_start) n_start <= n_start + 1;
        if (xfer_complete_o) n_cmpl  <= n_cmpl + 1;
        if (request_cmd12_o) n_cmd12 <= n_cmd12 + 1;
        if (crc_err_o)       n_crc   <= n_crc + 1;
        if (end_err_o)       n_end   <= n_end + 1;
        if (timeout_err_o)   n_tmo   <= n_tmo + 1;
        if (width_err_o)     n_werr  <= n_werr + 1;
        if (gap_event_o)     n_gap   <= n_gap + 1;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One transfer against a reactive card/buffer/engine model; expectations
    // come from block arithmetic on the transfer parameters.
    task automatic run_xfer(input bit rd, input int cnt, input bit a12, input int err_blk,
                            input bit err_crc, input int hold, input int stall,
                            input bit hang, input bit gap);
        int nblk, done_blk, busy, cyc, budget, stall_t, rel_t, left_t, gap_wait;
        int tmo_c0, tmo_c1, rel_cyc, cmpl_cyc, exp_gaps, exp_starts, exp_left;
        int early, stall_ok, gap_bad, gap_pause, wrong_act, gate_bad;
        int s_start, s_cmpl, s_cmd12, s_crc, s_end, s_tmo, s_werr, s_gap;
        bit running, stall_on, rel_on, released, finished;
        logic [1:0] w;
        nblk = (cnt == 0) ? 1 : cnt;
        done_blk = 0; busy = 0; cyc = 0; stall_t = 0; rel_t = 0; left_t = 0; gap_wait = 0;
        tmo_c0 = -1; tmo_c1 = -1; rel_cyc = 0; cmpl_cyc = 0;
        early = 0; stall_ok = 0; gap_bad = 0; gap_pause = 0; wrong_act = 0; gate_bad = 0;
        running = 0; stall_on = 0; rel_on = 0; released = 0; finished = 0;
        budget = hang ? 9000 : 3000 + hold + stall;
        w = 2'($urandom_range(0, 1));
        s_start = n_start; s_cmpl = n_cmpl; s_cmd12 = n_cmd12; s_crc = n_crc;
        s_end = n_end; s_tmo = n_tmo; s_werr = n_werr; s_gap = n_gap;

        @(negedge clk_i);
        dir_read_i = rd; bus_width_i = w; block_count_i = 16'(cnt); auto_cmd12_en_i = a12;
        timeout_sel_i = hang ? 4'd0 : 4'($urandom_range(0, 15));
        stop_gap_i = gap; buf_space_i = 1'b1; buf_avail_i = 1'b1; buf_empty_i = 1'b0; dat0_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("eng_width", eng_width_o, w);
        // The other direction's done must not advance the sequencer.
        if (rd) rsp_done_i = 1'b1; else cmd_done_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            rsp_done_i = 1'b0; cmd_done_i = 1'b0;
            if (eng_start_o) gate_bad++;
        end
        if (rd) cmd_done_i = 1'b1; else rsp_done_i = 1'b1;

        while (!finished && cyc < budget) begin
            @(negedge clk_i);
            cyc++;
            cmd_done_i = 1'b0; rsp_done_i = 1'b0; continue_i = 1'b0;
            eng_done_i = 1'b0; eng_crc_err_i = 1'b0; eng_end_err_i = 1'b0;
            if (rd ? write_active_o : read_active_o) wrong_act++;
            if (timeout_err_o && tmo_c1 < 0) tmo_c1 = cyc;
            if (xfer_complete_o && !released && err_blk == 0 && !hang) early++;
            if (xfer_complete_o) begin finished = 1; cmpl_cyc = cyc; end
            if (stall_on) begin
                stall_t++;
                if (stall_t >= 2 && stall_t <= stall + 1 && pause_sd_clk_o && !eng_start_o) stall_ok++;
                if (stall_t == stall + 1) begin buf_space_i = 1'b1; stall_on = 0; end
            end
            if (gap_wait > 0) begin
                if (eng_start_o) gap_bad++;
                if (pause_sd_clk_o) gap_pause++;
                gap_wait--;
                if (gap_wait == 0) continue_i = 1'b1;
            end else if (gap_event_o) begin
                gap_wait = 8;
            end
            if (left_t > 0) begin
                left_t--;
                if (left_t == 0) chk("left_blk", blocks_left_o, nblk - done_blk);
            end
            if (rel_on) begin
                if (rel_t >= hold) begin
                    dat0_i = 1'b1; buf_empty_i = 1'b1; released = 1; rel_on = 0; rel_cyc = cyc;
                end else begin
                    rel_t++;
                end
            end
            sd_clk_en_p_i = ($urandom_range(0, 2) != 0);
            if (running) begin
                if (!hang) begin
                    busy--;
                    if (busy == 0) begin
                        running = 0; eng_waiting_i = 1'b0; eng_done_i = 1'b1; done_blk++;
                        if (done_blk == err_blk) begin
                            eng_crc_err_i = err_crc; eng_end_err_i = !err_crc;
                        end
                        left_t = 2;
                        if (done_blk == 1 && stall > 0) begin
                            stall_on = 1; stall_t = 0; buf_space_i = 1'b0;
                        end
                        if (done_blk == nblk) begin
                            rel_on = 1; rel_t = 0; dat0_i = 1'b0;
                        end
                    end
                end
            end else if (eng_start_o && sd_clk_en_p_i) begin
                running = 1; busy = $urandom_range(4, 12); eng_waiting_i = 1'b1;
                if (tmo_c0 < 0) tmo_c0 = cyc;
            end
        end
        chk("cmpl_seen", longint'(finished), 1);
        repeat (3) @(negedge clk_i);
        stop_gap_i = 1'b0; eng_waiting_i = 1'b0; dat0_i = 1'b1; buf_empty_i = 1'b1;

        exp_starts = hang ? 1 : ((err_blk != 0) ? err_blk : nblk);
        exp_left   = hang ? nblk : ((err_blk != 0) ? nblk - err_blk : 0);
`ifdef SDHCI_DAT_BLOCK_GAP_EN
        exp_gaps = gap ? nblk - 1 : 0;
`else
        exp_gaps = 0;
`endif
        chk("dir_gate", gate_bad, 0);
        chk("starts", n_start - s_start, exp_starts);
        chk("cmpl_cnt", n_cmpl - s_cmpl, 1);
        chk("cmd12", n_cmd12 - s_cmd12, a12);
        chk("crc_err", n_crc - s_crc, (err_blk != 0 && !hang && err_crc) ? 1 : 0);
        chk("end_err", n_end - s_end, (err_blk != 0 && !hang && !err_crc) ? 1 : 0);
        chk("tmo_err", n_tmo - s_tmo, hang);
        chk("width_err", n_werr - s_werr, 0);
        chk("left_end", blocks_left_o, exp_left);
        chk("wrong_act", wrong_act, 0);
        chk("idle_act", {read_active_o, write_active_o}, 0);
        if (err_blk == 0 && !hang) begin
            chk("early_cmpl", early, 0);
            chk("cmpl_lat", longint'(cmpl_cyc - rel_cyc <= 4), 1);
        end
        if (stall > 0) chk("stall_pause", stall_ok, stall);
        if (gap) begin
            chk("gap_evt", n_gap - s_gap, exp_gaps);
            chk("gap_start", gap_bad, 0);
            chk("gap_pause", gap_pause, 8 * exp_gaps);
        end
        if (hang) chk("tmo_window", longint'(tmo_c1 - tmo_c0 >= 8193 && tmo_c1 - tmo_c0 <= 8197), 1);
    endtask

    task automatic width_err_case(input logic [1:0] w);
        int s_werr, s_start, act;
        s_werr = n_werr; s_start = n_start; act = 0;
        @(negedge clk_i);
        dir_read_i = 1'b1; bus_width_i = w; block_count_i = 16'd1; buf_space_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; cmd_done_i = 1'b1;
        repeat (6) @(negedge clk_i) begin
            cmd_done_i = 1'b0;
            if (read_active_o) act++;
        end
        chk("werr_pulse", n_werr - s_werr, 1);
        chk("werr_idle", act, 0);
        chk("werr_nostart", n_start - s_start, 0);
    endtask

    initial begin
        int k, rc, rerr, rhold, rstall, s_cmpl, s_cmd12;
        bit rrd, ra12, rcrc;
        repeat (3) @(negedge clk_i);
        chk("rst_outs", {eng_start_o, eng_width_o, pause_sd_clk_o, read_active_o, write_active_o,
                         request_cmd12_o, gap_event_o, xfer_complete_o, crc_err_o, end_err_o,
                         timeout_err_o, width_err_o, blocks_left_o}, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_xfer(1, 1, 0, 0, 0, 5, 0, 0, 0);      // single read
        run_xfer(0, 3, 1, 0, 0, 100, 0, 0, 0);    // 3-block write, long busy
        run_xfer(1, 3, 0, 0, 0, 4, 50, 0, 0);     // read, buffer full for 50 cycles
        run_xfer(1, 2, 1, 0, 0, 0, 0, 1, 0);      // engine never finishes
        run_xfer(1, 4, 0, 0, 0, 3, 0, 0, 1);      // stop at block gap
        run_xfer(0, 0, 0, 0, 0, 2, 0, 0, 0);      // count 0 means one block
        run_xfer(0, 3, 1, 2, 1, 2, 0, 0, 0);      // CRC error on block 2
        run_xfer(1, 2, 1, 2, 0, 2, 0, 0, 0);      // end-bit error on last block
        width_err_case(2'd2);
        width_err_case(2'd3);

        // Reset in the middle of a transfer.
        @(negedge clk_i);
        dir_read_i = 1'b1; bus_width_i = 2'd1; block_count_i = 16'd3; auto_cmd12_en_i = 1'b1;
        buf_space_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; cmd_done_i = 1'b1;
        @(negedge clk_i);
        cmd_done_i = 1'b0;
        k = 0;
        while (!eng_start_o && k < 20) begin @(negedge clk_i); k++; end
        chk("rstm_reach", eng_start_o, 1);
        s_cmpl = n_cmpl; s_cmd12 = n_cmd12;
        rst_ni = 1'b0;
        #1;
        chk("rstm_outs", {eng_start_o, read_active_o, pause_sd_clk_o, eng_width_o, blocks_left_o}, 0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("rstm_pulses", (n_cmpl - s_cmpl) + (n_cmd12 - s_cmd12), 0);
        chk("rstm_idle", read_active_o, 0);

        for (int t = 0; t < 8; t++) begin
            rrd  = 1'($urandom_range(0, 1));
            ra12 = 1'($urandom_range(0, 1));
            rcrc = 1'($urandom_range(0, 1));
            rc   = int'($urandom_range(0, 5));
            k    = (rc == 0) ? 1 : rc;
            rerr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, k)) : 0;
            rhold = int'($urandom_range(0, 20));
            rstall = (rrd && k >= 2 && rerr != 1 && $urandom_range(0, 1) == 1) ?
                     int'($urandom_range(5, 20)) : 0;
            run_xfer(rrd, rc, ra12, rerr, rcrc, rhold, rstall, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
